// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: oversamples i_rx and strobes each sampled bit into an external SIPO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_shift_ena,
  output logic o_shift_bit,
  output logic o_done,
  output logic o_frame_err,
  output logic o_parity_err,
  output logic o_busy
);

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_W     = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             rx_meta, rx_s, rx_prev;
  logic             shift_ena_d, shift_bit_d, done_d, frame_err_d, busy_d;

`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      o_shift_ena <= 1'b0;
      o_shift_bit <= 1'b0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      o_shift_ena <= shift_ena_d;
      o_shift_bit <= shift_bit_d;
      o_done      <= done_d;
      o_frame_err <= frame_err_d;
      o_busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_ena_d = 1'b0;
    shift_bit_d = 1'b0;
    done_d      = 1'b0;
    frame_err_d = o_frame_err;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = parity_err_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s) begin
          state_d = START;
        end
      end

      // Re-check the start bit at mid-bit to reject glitches
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            shift_ena_d = 1'b1;
            shift_bit_d = 1'b0;
            bit_d       = '0;
            frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_d        = 1'b0;
            parity_err_d = 1'b0;
`endif
            state_d     = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          shift_ena_d = 1'b1;
          shift_bit_d = rx_s;
          bit_d       = bit_q + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
          par_d       = par_q ^ rx_s;
`endif
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          shift_ena_d  = 1'b1;
          shift_bit_d  = rx_s;
          parity_err_d = par_q ^ rx_s;
          state_d      = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          shift_ena_d = 1'b1;
          shift_bit_d = rx_s;
          frame_err_d = ~rx_s;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // o_done lands one cycle later, once the SIPO has taken the stop bit
      DONE: begin
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a SIPO model and a frame scoreboard.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned SDW = 11;
`else
  localparam int unsigned SDW = 10;
`endif

  typedef struct {
    logic [SDW-1:0] sipo;
    logic           ferr;
    logic           perr;
  } exp_t;

  logic clk;
  logic rst;
  logic i_rx;
  logic o_shift_ena, o_shift_bit, o_done, o_frame_err, o_parity_err, o_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_shifts = 0;
  int total_shifts = 0;
  int last_cyc     = 0;
  int n_done       = 0;
  int n_pushed     = 0;
  logic prev_ena   = 1'b0;
  logic [SDW-1:0] sipo = '0;
  exp_t exp_q[$];

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_shift_ena  (o_shift_ena),
    .o_shift_bit  (o_shift_bit),
    .o_done       (o_done),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SIPO model and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      frame_shifts <= 0;
      prev_ena     <= 1'b0;
    end else begin
      prev_ena <= o_shift_ena;
      if (o_shift_ena) begin
        check("no_back_to_back_shift", 32'(prev_ena), 32'd0);
        if (frame_shifts != 0) check("shift_spacing", 32'(cyc - last_cyc), 32'(CPB));
        if (frame_shifts == 1) begin
          check("frame_err_cleared", 32'(o_frame_err), 32'd0);
          check("parity_err_cleared", 32'(o_parity_err), 32'd0);
        end
        sipo         <= {o_shift_bit, sipo[SDW-1:1]};
        frame_shifts <= frame_shifts + 1;
        total_shifts <= total_shifts + 1;
        last_cyc     <= cyc;
      end
      if (o_done) begin
        exp_t e;
        n_done <= n_done + 1;
        check("done_has_pending_frame", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sipo_frame", 32'(sipo), 32'(e.sipo));
          check("shift_count", 32'(frame_shifts), 32'(SDW));
          check("frame_err", 32'(o_frame_err), 32'(e.ferr));
          check("parity_err", 32'(o_parity_err), 32'(e.perr));
        end
        frame_shifts <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (CPB) tick();
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    exp_t e;
`ifdef UART_RX_PARITY_EN
    e.sipo = {stop, par, data, 1'b0};
    e.perr = (^data) ^ par;
`else
    e.sipo = {stop, data, 1'b0};
    e.perr = 1'b0;
`endif
    e.ferr = ~stop;
    exp_q.push_back(e);
    n_pushed++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  initial begin
    int shifts_before;
    rst  = 1'b0;
    i_rx = 1'b1;
    repeat (3) tick();
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_shift_ena", 32'(o_shift_ena), 32'd0);
    check("reset_shift_bit", 32'(o_shift_bit), 32'd0);
    check("reset_done", 32'(o_done), 32'd0);
    check("reset_frame_err", 32'(o_frame_err), 32'd0);
    check("reset_parity_err", 32'(o_parity_err), 32'd0);
    rst = 1'b1;
    idle(10);

    send_frame(8'h55, 1'b1, ^8'h55);
    idle(20);
    check("queue_drained_0x55", 32'(exp_q.size()), 32'd0);
    check("idle_after_0x55", 32'(o_busy), 32'd0);

    // Short low glitch must be rejected at mid-start-bit
    shifts_before = total_shifts;
    i_rx = 1'b0;
    tick();
    tick();
    i_rx = 1'b1;
    tick();
    tick();
    check("glitch_busy_in_start", 32'(o_busy), 32'd1);
    idle(12);
    check("glitch_busy_cleared", 32'(o_busy), 32'd0);
    check("glitch_no_shift", 32'(total_shifts), 32'(shifts_before));

    send_frame(8'hA3, 1'b0, ^8'hA3);
    idle(20);
    check("frame_err_held", 32'(o_frame_err), 32'd1);

    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle(20);
    check("queue_drained_b2b", 32'(exp_q.size()), 32'd0);

    // Abort after the 4th data shift; no frame is expected from it
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("abort_shifts_seen", 32'(frame_shifts), 32'd5);
    rst  = 1'b0;
    i_rx = 1'b1;
    #1;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_shift_ena", 32'(o_shift_ena), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    idle(10);
    check("abort_no_done", 32'(n_done), 32'(n_pushed));

    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle(20);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("parity_err_set", 32'(o_parity_err), 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("parity_err_clear", 32'(o_parity_err), 32'd0);
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_done_count", 32'(n_done), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
